// File: rtl/data_memory.sv
// Word-addressed single-port data RAM for the memory stage.
// Synchronous write and clear; combinational, enable-gated read with range check.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      index;
  logic                  in_range;

  // Addresses at or beyond DEPTH never alias onto a stored word.
  always_comb begin
    index    = address[IDX_W-1:0];
    in_range = ((address >> IDX_W) == '0);
  end

  // Reset clears the array and takes priority over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (mem_wr && in_range) begin
      mem[index] <= write_data;
    end
  end

  // No write-through: a same-cycle write only becomes visible after the edge.
  always_comb begin
    read_data = '0;
    if (mem_rd && in_range) begin
      read_data = mem[index];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: scoreboard queue of expected read values,
// a vector table for access corner cases, and hand-written fill/reset sequences.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] read_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] address;
    logic [31:0] write_data;
    logic        rd;
    logic        wr;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  data_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .write_data(write_data),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got empty scoreboard expected an entry", name);
    end else begin
      check(name, read_data, exp_q.pop_front());
    end
  endtask

  // Read every word combinationally (no clock) and expect the given value.
  task automatic sweep_expect(input string name, input logic [31:0] base, input bit plus_addr);
    for (int a = 0; a < 32; a++) begin
      address = 32'(a);
      mem_rd  = 1'b1;
      mem_wr  = 1'b0;
      exp_q.push_back(plus_addr ? 32'(a) + base : base);
      #1;
      sb_compare($sformatf("%s[%0d]", name, a));
    end
  endtask

  initial begin
    vecs[0]  = '{32'd5,          32'h0,        1'b0, 1'b0, 32'd0,        32'd0};
    vecs[1]  = '{32'd5,          32'h0,        1'b1, 1'b0, 32'd6,        32'd6};
    vecs[2]  = '{32'd32,         32'hDEADBEEF, 1'b1, 1'b1, 32'd0,        32'd0};
    vecs[3]  = '{32'd3,          32'h0,        1'b1, 1'b0, 32'd4,        32'd4};
    vecs[4]  = '{32'h1000_0003,  32'hDEADBEEF, 1'b1, 1'b1, 32'd0,        32'd0};
    vecs[5]  = '{32'd3,          32'h0,        1'b1, 1'b0, 32'd4,        32'd4};
    vecs[6]  = '{32'd0,          32'h0,        1'b1, 1'b0, 32'd1,        32'd1};
    vecs[7]  = '{32'd7,          32'hA5A5A5A5, 1'b1, 1'b1, 32'd8,        32'hA5A5A5A5};
    vecs[8]  = '{32'd8,          32'h0,        1'b1, 1'b0, 32'd9,        32'd9};
    vecs[9]  = '{32'd31,         32'h12345678, 1'b0, 1'b1, 32'd0,        32'd0};
    vecs[10] = '{32'd31,         32'h0,        1'b1, 1'b0, 32'h12345678, 32'h12345678};
    vecs[11] = '{32'd30,         32'h0,        1'b1, 1'b0, 32'd31,       32'd31};

    reset      = 1'b1;
    address    = '0;
    write_data = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    sweep_expect("after_reset", 32'd0, 1'b0);

    // Fill: each written word is readable in the cycle after its write edge.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      address    = 32'(a);
      write_data = 32'(a) + 32'd1;
      mem_wr     = 1'b1;
      mem_rd     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      mem_wr = 1'b0;
      mem_rd = 1'b1;
      exp_q.push_back(32'(a) + 32'd1);
      #1;
      sb_compare($sformatf("fill_read[%0d]", a));
    end

    // Scrambled-order reread; addresses change with no clock edge in between.
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      int a;
      a       = (k * 7 + 3) % 32;
      address = 32'(a);
      mem_rd  = 1'b1;
      mem_wr  = 1'b0;
      exp_q.push_back(32'(a) + 32'd1);
      #1;
      sb_compare($sformatf("reread[%0d]", a));
    end

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      address    = vecs[v].address;
      write_data = vecs[v].write_data;
      mem_rd     = vecs[v].rd;
      mem_wr     = vecs[v].wr;
      exp_q.push_back(vecs[v].exp_pre);
      #1;
      sb_compare($sformatf("vec%0d_pre", v));
      exp_q.push_back(vecs[v].exp_post);
      @(posedge clk);
      #1;
      sb_compare($sformatf("vec%0d_post", v));
      mem_wr = 1'b0;
    end

    // Reset with a competing write: the write is dropped and everything clears.
    @(negedge clk);
    reset      = 1'b1;
    mem_wr     = 1'b1;
    mem_rd     = 1'b1;
    address    = 32'd2;
    write_data = 32'h55;
    exp_q.push_back(32'd3);
    #1;
    sb_compare("reset_pre_read2");
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mem_wr = 1'b0;
    sweep_expect("after_mid_reset", 32'd0, 1'b0);

    // Memory is writable again after the clear.
    @(negedge clk);
    address    = 32'd2;
    write_data = 32'h55;
    mem_wr     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_wr = 1'b0;
    exp_q.push_back(32'h55);
    #1;
    sb_compare("post_reset_write2");
    address = 32'd3;
    exp_q.push_back(32'd0);
    #1;
    sb_compare("post_reset_neighbour3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
